rr_arbiter4: RTL and testbench

Four-way round-robin arbiter that shares one decoded resource slot between four requesters. It produces a 2-bit grant index plus a grant-valid enable, and the one-hot grant vector is their 2-to-4 decode gated by the enable. Grants are registered and sticky while the owner keeps requesting. Grants are preempted after `MAX_HOLD` cycles when another requester is waiting. The block sits in front of the 2-to-4 decoder select/enable path and drives it directly.

---
 rtl/rr_arbiter4.sv | 90 +++++++++
 tb/tb_rr_arbiter4.sv | 137 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered, sticky grants and hold-time preemption.
// Drives a 2-to-4 decoder through gnt_idx/gnt_valid; gnt is the gated decode of both.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic [3:0] others;
  logic [1:0] after_owner;

  // First set bit of mask scanning start, start+1, ... with wrap 3->0.
  function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] cand;
    pick = start;
    for (int i = 3; i >= 0; i--) begin
      cand = start + 2'(i);
      if (mask[cand]) pick = cand;
    end
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_idx_d   = gnt_idx_q;
    others      = req & ~(4'b0001 << gnt_idx_q);
    after_owner = gnt_idx_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = GRANT;
          gnt_idx_d  = pick(req, ptr_q);
          hold_cnt_d = 8'd1;
        end
      end
      GRANT: begin
        // Release and preemption share the handover path; only release can fall back to IDLE.
        if (!req[gnt_idx_q] || (hold_cnt_q == HOLD_MAX && |others)) begin
          ptr_d = after_owner;
          if (|others) begin
            gnt_idx_d  = pick(others, after_owner);
            hold_cnt_d = 8'd1;
          end else begin
            state_d    = IDLE;
            hold_cnt_d = 8'd0;
          end
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      hold_cnt_q <= 8'd0;
      gnt_idx_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_idx_q  <= gnt_idx_d;
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = gnt_idx_q;
  assign gnt       = gnt_valid ? (4'b0001 << gnt_idx_q) : 4'b0000;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: two instances (MAX_HOLD 4 and 3) share clock, reset and requests.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] gnt_idx_a, gnt_idx_b;
  logic       gnt_valid_a, gnt_valid_b;

  int n_assert = 0;
  int n_fail   = 0;

  rr_arbiter4 #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_a), .gnt_idx(gnt_idx_a), .gnt_valid(gnt_valid_a)
  );

  rr_arbiter4 #(.MAX_HOLD(3)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_b), .gnt_idx(gnt_idx_b), .gnt_valid(gnt_valid_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed {valid,idx,gnt}=%b required=%b", tag, observed, expected);
    end
  endtask

  task automatic expect_a(input string tag, input logic v, input logic [1:0] idx, input logic [3:0] g);
    check({tag, " (hold4)"}, {gnt_valid_a, gnt_idx_a, gnt_a}, {v, idx, g});
  endtask

  task automatic expect_b(input string tag, input logic v, input logic [1:0] idx, input logic [3:0] g);
    check({tag, " (hold3)"}, {gnt_valid_b, gnt_idx_b, gnt_b}, {v, idx, g});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] own;
    rst = 1'b0;
    req = 4'b0000;
    #2 rst = 1'b1;
    #1;
    expect_a("reset state", 1'b0, 2'd0, 4'b0000);
    expect_b("reset state", 1'b0, 2'd0, 4'b0000);
    step();
    rst = 1'b0;

    // Single requester 2 for five cycles, then drop.
    req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      step();
      expect_a("sole req2 held", 1'b1, 2'd2, 4'b0100);
    end
    req = 4'b0000;
    expect_a("owner sees gnt after drop", 1'b1, 2'd2, 4'b0100);
    step();
    expect_a("release to idle, idx sticky", 1'b0, 2'd2, 4'b0000);

    // ptr is now 3: 1001 requested together must favour requester 3, then wrap to 0.
    req = 4'b1001;
    step();
    expect_a("wrap first grant 3", 1'b1, 2'd3, 4'b1000);
    req = 4'b0001;
    step();
    expect_a("wrap handover to 0", 1'b1, 2'd0, 4'b0001);
    req = 4'b0000;
    step();
    expect_a("wrap release idle", 1'b0, 2'd0, 4'b0000);

    // ptr is 1: owner 1 with 3 waiting, then owner drops -> no bubble.
    req = 4'b0010;
    step();
    expect_a("owner1 grant", 1'b1, 2'd1, 4'b0010);
    req = 4'b1010;
    step();
    expect_a("owner1 sticky vs req3", 1'b1, 2'd1, 4'b0010);
    req = 4'b1000;
    step();
    expect_a("handover 1->3 no bubble", 1'b1, 2'd3, 4'b1000);
    req = 4'b0000;
    step();
    expect_a("idle after owner3", 1'b0, 2'd3, 4'b0000);

    // Full contention from reset with MAX_HOLD=4: owners 0,1,2,3,0, four cycles each.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      step();
      own = 2'((k / 4) % 4);
      expect_a($sformatf("rotate cycle %0d", k), 1'b1, own, 4'b0001 << own);
    end

    // Sole requester 0 beyond MAX_HOLD, then requester 2 preempts on first sample.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step();
      expect_b($sformatf("sole req0 cycle %0d", c), 1'b1, 2'd0, 4'b0001);
    end
    req = 4'b0101;
    step();
    expect_b("saturated owner preempted", 1'b1, 2'd2, 4'b0100);
    expect_a("saturated owner preempted", 1'b1, 2'd2, 4'b0100);

    // Asynchronous reset between edges drops the grant at once.
    #3 rst = 1'b1;
    #1;
    expect_a("async reset mid-grant", 1'b0, 2'd0, 4'b0000);
    expect_b("async reset mid-grant", 1'b0, 2'd0, 4'b0000);
    req = 4'b0110;
    step();
    expect_a("held in reset", 1'b0, 2'd0, 4'b0000);
    rst = 1'b0;
    step();
    expect_a("post-reset ptr 0 picks 1", 1'b1, 2'd1, 4'b0010);
    expect_b("post-reset ptr 0 picks 1", 1'b1, 2'd1, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
